// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the 5-stage core hazard/sequencing controller:
//   - controller FSM state encoding
//   - default performance-counter width
//   - load-use hazard detection helper
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // Controller states. The encodings are fixed so that debug taps and
    // waveform decoders can rely on them.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LSU_WAIT  = 2'd1,
        ST_CSR_DRAIN = 2'd2
    } hz_state_e;

    localparam int unsigned CNT_W_DEFAULT = 32;

    // True when the instruction in ID needs a register that the load in EXE
    // has not produced yet. x0 is never a real dependency.
    function automatic logic load_use_hazard(
        input logic       exe_load,
        input logic       exe_rd_en,
        input logic [4:0] exe_rd_idx,
        input logic       rs1_en,
        input logic [4:0] rs1_idx,
        input logic       rs2_en,
        input logic [4:0] rs2_idx
    );
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = rs1_en && (rs1_idx == exe_rd_idx);
        rs2_hit = rs2_en && (rs2_idx == exe_rd_idx);
        return exe_load && exe_rd_en && (exe_rd_idx != 5'd0) && (rs1_hit || rs2_hit);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Decode side (ID):   id_rs1_en, id_rs2_en, id_rs1_idx, id_rs2_idx
//   Execute side (EXE): exe_load, exe_ls, exe_csr, exe_rd_en, exe_rd_idx,
//                       exe_redirect, exe_target
//   LSU handshake:      lsu_ready
//   Controls out:       pc_hold, if_id_hold, if_id_flush, id_exe_hold,
//                       lu_flush, b_flush, exe_mem_hold,
//                       redirect_valid, redirect_pc
//   Status out:         lsu_timeout_err, stall_cnt, flush_cnt
// Modports:
//   slave  - the hazard controller (consumes status, drives controls)
//   master - the pipeline side (drives status, consumes controls)
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_rs1_en;
    logic             id_rs2_en;
    logic [4:0]       id_rs1_idx;
    logic [4:0]       id_rs2_idx;
    logic             exe_load;
    logic             exe_ls;
    logic             exe_csr;
    logic             exe_rd_en;
    logic [4:0]       exe_rd_idx;
    logic             exe_redirect;
    logic [31:0]      exe_target;
    logic             lsu_ready;

    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_exe_hold;
    logic             lu_flush;
    logic             b_flush;
    logic             exe_mem_hold;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             lsu_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_rs1_en, id_rs2_en, id_rs1_idx, id_rs2_idx,
               exe_load, exe_ls, exe_csr, exe_rd_en, exe_rd_idx,
               exe_redirect, exe_target, lsu_ready,
        output pc_hold, if_id_hold, if_id_flush, id_exe_hold,
               lu_flush, b_flush, exe_mem_hold,
               redirect_valid, redirect_pc,
               lsu_timeout_err, stall_cnt, flush_cnt
    );

    modport master (
        output id_rs1_en, id_rs2_en, id_rs1_idx, id_rs2_idx,
               exe_load, exe_ls, exe_csr, exe_rd_en, exe_rd_idx,
               exe_redirect, exe_target, lsu_ready,
        input  pc_hold, if_id_hold, if_id_flush, id_exe_hold,
               lu_flush, b_flush, exe_mem_hold,
               redirect_valid, redirect_pc,
               lsu_timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// perf_cnt
// Free-running event counter: adds one on every clock where i_en is high.
// Wraps modulo 2^CNT_W. Asynchronous active-low reset to zero.
//   clk   - core clock
//   rstn  - asynchronous active-low reset
//   i_en  - count this cycle
//   o_cnt - current count
// -----------------------------------------------------------------------------
module perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard and sequencing controller for the 5-stage core. Produces the
// hold/flush controls for PC, IF/ID, ID/EXE and EXE/MEM, serialises CSR
// accesses, waits on (and watchdogs) the LSU handshake and counts stall and
// branch-flush cycles.
// Ports:
//   clk   - core clock
//   rstn  - asynchronous active-low reset
//   bus   - pipe_hazard_ctrl_if.slave: decode/execute status in,
//           pipeline controls, watchdog error and perf counters out
// Parameters:
//   CSR_DRAIN_CYC - extra stall cycles after a CSR reaches EXE (1..15)
//   LSU_TIMEOUT   - LSU_WAIT cycles tolerated before the watchdog fires
//   CNT_W         - perf-counter width (must match the interface CNT_W)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CSR_DRAIN_CYC = 2,
    parameter int unsigned LSU_TIMEOUT   = 255,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [3:0] DRAIN_INIT = 4'(CSR_DRAIN_CYC);
    localparam logic [7:0] WAIT_LIMIT = 8'(LSU_TIMEOUT);

    hz_state_e   r_state;
    hz_state_e   w_state_next;
    logic [3:0]  r_drain_cnt;
    logic [3:0]  w_drain_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_next;
    logic        r_timeout_err;
    logic        w_timeout_set;

    logic        w_lu;
    logic        w_pc_hold;
    logic        w_if_id_hold;
    logic        w_if_id_flush;
    logic        w_id_exe_hold;
    logic        w_lu_flush;
    logic        w_b_flush;
    logic        w_exe_mem_hold;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;

    assign w_lu = load_use_hazard(bus.exe_load, bus.exe_rd_en, bus.exe_rd_idx,
                                  bus.id_rs1_en, bus.id_rs1_idx,
                                  bus.id_rs2_en, bus.id_rs2_idx);

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_next;
            r_wait_cnt  <= w_wait_next;
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_drain_next     = r_drain_cnt;
        w_wait_next      = r_wait_cnt;
        w_timeout_set    = 1'b0;
        w_pc_hold        = 1'b0;
        w_if_id_hold     = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_exe_hold    = 1'b0;
        w_lu_flush       = 1'b0;
        w_b_flush        = 1'b0;
        w_exe_mem_hold   = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'd0;

        unique case (r_state)
            ST_RUN: begin
                if (bus.exe_redirect) begin
                    // Wrong-path instructions in IF/ID and ID are squashed;
                    // any load-use or CSR stall would only delay the restart.
                    w_b_flush        = 1'b1;
                    w_if_id_flush    = 1'b1;
                    w_redirect_valid = 1'b1;
                    w_redirect_pc    = bus.exe_target;
                end else if (bus.exe_ls && !bus.lsu_ready) begin
                    // Freeze the whole front of the pipe; the ID instruction
                    // is held rather than bubbled, so no lu_flush here.
                    w_pc_hold      = 1'b1;
                    w_if_id_hold   = 1'b1;
                    w_id_exe_hold  = 1'b1;
                    w_exe_mem_hold = 1'b1;
                    w_state_next   = ST_LSU_WAIT;
                    w_wait_next    = 8'd1;
                end else if (bus.exe_csr) begin
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                    w_lu_flush   = 1'b1;
                    w_state_next = ST_CSR_DRAIN;
                    w_drain_next = DRAIN_INIT;
                end else if (w_lu) begin
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                    w_lu_flush   = 1'b1;
                end
            end

            ST_LSU_WAIT: begin
                // EXE is frozen, so exe_redirect is intentionally not looked
                // at; it is seen again once the access completes.
                w_pc_hold      = 1'b1;
                w_if_id_hold   = 1'b1;
                w_id_exe_hold  = 1'b1;
                w_exe_mem_hold = 1'b1;
                if (bus.lsu_ready) begin
                    w_state_next = ST_RUN;
                    w_wait_next  = 8'd0;
                end else if (r_wait_cnt >= WAIT_LIMIT) begin
                    w_timeout_set = 1'b1;
                    w_state_next  = ST_RUN;
                    w_wait_next   = 8'd0;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end

            ST_CSR_DRAIN: begin
                w_pc_hold    = 1'b1;
                w_if_id_hold = 1'b1;
                w_lu_flush   = 1'b1;
                // Exits on the cycle the counter shows 1, giving
                // CSR_DRAIN_CYC drain cycles after the entry cycle.
                if (r_drain_cnt <= 4'd1) begin
                    w_state_next = ST_RUN;
                    w_drain_next = 4'd0;
                end else begin
                    w_drain_next = r_drain_cnt - 4'd1;
                end
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: forced quiet while reset is asserted
    // -------------------------------------------------------------------------
    assign bus.pc_hold         = rstn & w_pc_hold;
    assign bus.if_id_hold      = rstn & w_if_id_hold;
    assign bus.if_id_flush     = rstn & w_if_id_flush;
    assign bus.id_exe_hold     = rstn & w_id_exe_hold;
    assign bus.lu_flush        = rstn & w_lu_flush;
    assign bus.b_flush         = rstn & w_b_flush;
    assign bus.exe_mem_hold    = rstn & w_exe_mem_hold;
    assign bus.redirect_valid  = rstn & w_redirect_valid;
    assign bus.redirect_pc     = {32{rstn}} & w_redirect_pc;
    assign bus.lsu_timeout_err = r_timeout_err;

    // -------------------------------------------------------------------------
    // Performance counters: [0] stall cycles, [1] branch-flush cycles
    // -------------------------------------------------------------------------
    logic [1:0]       w_cnt_en;
    logic [CNT_W-1:0] w_cnt_val [2];

    assign w_cnt_en = {bus.b_flush, bus.pc_hold};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            perf_cnt #(
                .CNT_W (CNT_W)
            ) u_perf_cnt (
                .clk   (clk),
                .rstn  (rstn),
                .i_en  (w_cnt_en[gi]),
                .o_cnt (w_cnt_val[gi])
            );
        end
    endgenerate

    assign bus.stall_cnt = w_cnt_val[0];
    assign bus.flush_cnt = w_cnt_val[1];

    // Decode never marks one instruction as both a memory access and a CSR.
    a_ls_csr_exclusive: assert property (
        @(posedge clk) disable iff (!rstn) !(bus.exe_ls && bus.exe_csr)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int unsigned CNT_W = 32;

    // Control vector order:
    // {pc_hold, if_id_hold, if_id_flush, id_exe_hold, lu_flush, b_flush, exe_mem_hold, redirect_valid}
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1100_1000;
    localparam logic [7:0] C_CSR   = 8'b1100_1000;
    localparam logic [7:0] C_REDIR = 8'b0010_0101;
    localparam logic [7:0] C_LSU   = 8'b1101_0010;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .CSR_DRAIN_CYC (2),
        .LSU_TIMEOUT   (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [7:0] ctl;
    assign ctl = {bus.pc_hold, bus.if_id_hold, bus.if_id_flush, bus.id_exe_hold,
                  bus.lu_flush, bus.b_flush, bus.exe_mem_hold, bus.redirect_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.id_rs1_en    = 1'b0;
        bus.id_rs2_en    = 1'b0;
        bus.id_rs1_idx   = 5'd0;
        bus.id_rs2_idx   = 5'd0;
        bus.exe_load     = 1'b0;
        bus.exe_ls       = 1'b0;
        bus.exe_csr      = 1'b0;
        bus.exe_rd_en    = 1'b0;
        bus.exe_rd_idx   = 5'd0;
        bus.exe_redirect = 1'b0;
        bus.exe_target   = 32'd0;
        bus.lsu_ready    = 1'b0;
    endtask

    // Advance one clock; afterwards we sit 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_en,
                            input logic [4:0] rs2, input logic rs2_en);
        bus.exe_load   = 1'b1;
        bus.exe_rd_en  = 1'b1;
        bus.exe_rd_idx = rd;
        bus.id_rs1_idx = rs1;
        bus.id_rs1_en  = rs1_en;
        bus.id_rs2_idx = rs2;
        bus.id_rs2_en  = rs2_en;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        bus.exe_redirect = 1'b1;
        bus.exe_target   = 32'hDEAD_BEEF;
        bus.exe_ls       = 1'b1;
        #12;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
        end
        n_vec++;
        if (bus.redirect_pc !== 32'd0) begin
            n_err++;
            $display("FAIL reset_redirect_pc: got %h want %h", bus.redirect_pc, 32'd0);
        end
        n_vec++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.lsu_timeout_err} !== {CNT_W'(0), CNT_W'(0), 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: stall=%0d flush=%0d err=%b want 0 0 0",
                     bus.stall_cnt, bus.flush_cnt, bus.lsu_timeout_err);
        end
        $display("reset: ctl=%b redirect_pc=%h", ctl, bus.redirect_pc);
    endtask

    task automatic test_load_use();
        do_reset();
        // rs1 dependency on x5
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        n_vec++;
        if (ctl !== C_LU) begin
            n_err++;
            $display("FAIL lu_rs1_ctl: got %b want %b", ctl, C_LU);
        end
        $display("load-use rs1=x5: ctl=%b", ctl);
        step();
        n_vec++;
        if (bus.stall_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt);
        end
        bus.exe_load = 1'b0;   // load has moved on to MEM
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lu_release_ctl: got %b want %b", ctl, C_NONE);
        end
        step();
        // rs2 dependency on x7, rs1 unrelated
        set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        #1;
        n_vec++;
        if (ctl !== C_LU) begin
            n_err++;
            $display("FAIL lu_rs2_ctl: got %b want %b", ctl, C_LU);
        end
        $display("load-use rs2=x7: ctl=%b", ctl);
        step();
        // Matching indices but neither source read
        set_load(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lu_noread_ctl: got %b want %b", ctl, C_NONE);
        end
        // Load without rd write enable
        set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        bus.exe_rd_en = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lu_nord_ctl: got %b want %b", ctl, C_NONE);
        end
        // Non-load producer (ALU result is forwarded, no stall)
        set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        bus.exe_load = 1'b0;
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lu_alu_ctl: got %b want %b", ctl, C_NONE);
        end
        step();
        n_vec++;
        if (bus.stall_cnt !== CNT_W'(2)) begin
            n_err++;
            $display("FAIL lu_stall_cnt2: got %0d want 2", bus.stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_x0();
        do_reset();
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL x0_ctl: got %b want %b", ctl, C_NONE);
        end
        $display("load x0: ctl=%b", ctl);
        step();
        n_vec++;
        if (bus.stall_cnt !== CNT_W'(0)) begin
            n_err++;
            $display("FAIL x0_stall_cnt: got %0d want 0", bus.stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        bus.exe_redirect = 1'b1;
        bus.exe_target   = 32'h0000_0100;
        #1;
        n_vec++;
        if ({ctl, bus.redirect_pc} !== {C_REDIR, 32'h0000_0100}) begin
            n_err++;
            $display("FAIL redir_lu: got ctl=%b pc=%h want ctl=%b pc=%h",
                     ctl, bus.redirect_pc, C_REDIR, 32'h0000_0100);
        end
        $display("redirect+lu: ctl=%b pc=%h", ctl, bus.redirect_pc);
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({bus.flush_cnt, bus.stall_cnt} !== {CNT_W'(1), CNT_W'(0)}) begin
            n_err++;
            $display("FAIL redir_cnts: flush=%0d stall=%0d want 1 0", bus.flush_cnt, bus.stall_cnt);
        end
        // Redirect together with a CSR: CSR drain must not start
        bus.exe_csr      = 1'b1;
        bus.exe_redirect = 1'b1;
        bus.exe_target   = 32'h0000_0040;
        #1;
        n_vec++;
        if ({ctl, bus.redirect_pc} !== {C_REDIR, 32'h0000_0040}) begin
            n_err++;
            $display("FAIL redir_csr: got ctl=%b pc=%h want ctl=%b pc=%h",
                     ctl, bus.redirect_pc, C_REDIR, 32'h0000_0040);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL redir_csr_after: got %b want %b", ctl, C_NONE);
        end
        $display("redirect+csr then idle: ctl=%b flush_cnt=%0d", ctl, bus.flush_cnt);
    endtask

    task automatic test_lsu_wait();
        do_reset();
        bus.exe_ls     = 1'b1;
        bus.exe_target = 32'h0000_0200;
        for (int c = 0; c < 4; c++) begin
            bus.lsu_ready    = (c == 3);
            bus.exe_redirect = (c == 1);   // must be ignored while waiting
            #1;
            n_vec++;
            if (ctl !== C_LSU) begin
                n_err++;
                $display("FAIL lsu_wait_c%0d: got %b want %b", c, ctl, C_LSU);
            end
            $display("lsu wait cycle %0d: ready=%b ctl=%b", c, bus.lsu_ready, ctl);
            step();
        end
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lsu_release: got %b want %b", ctl, C_NONE);
        end
        n_vec++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {CNT_W'(4), CNT_W'(0)}) begin
            n_err++;
            $display("FAIL lsu_cnts: stall=%0d flush=%0d want 4 0", bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_csr();
        do_reset();
        bus.exe_csr = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_CSR) begin
            n_err++;
            $display("FAIL csr_entry: got %b want %b", ctl, C_CSR);
        end
        step();
        bus.exe_csr = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #1;
            n_vec++;
            if (ctl !== C_CSR) begin
                n_err++;
                $display("FAIL csr_drain_c%0d: got %b want %b", c, ctl, C_CSR);
            end
            step();
        end
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL csr_release: got %b want %b", ctl, C_NONE);
        end
        n_vec++;
        if (bus.stall_cnt !== CNT_W'(3)) begin
            n_err++;
            $display("FAIL csr_stall_cnt: got %0d want 3", bus.stall_cnt);
        end
        $display("csr drain: stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_timeout();
        do_reset();
        bus.exe_ls    = 1'b1;
        bus.lsu_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++;
            if ({ctl, bus.lsu_timeout_err} !== {C_LSU, 1'b0}) begin
                n_err++;
                $display("FAIL to_wait_c%0d: ctl=%b err=%b want %b 0", c, ctl, bus.lsu_timeout_err, C_LSU);
            end
            step();
        end
        bus.exe_ls = 1'b0;
        #1;
        n_vec++;
        if ({ctl, bus.lsu_timeout_err} !== {C_NONE, 1'b1}) begin
            n_err++;
            $display("FAIL to_fire: ctl=%b err=%b want %b 1", ctl, bus.lsu_timeout_err, C_NONE);
        end
        n_vec++;
        if (bus.stall_cnt !== CNT_W'(5)) begin
            n_err++;
            $display("FAIL to_stall_cnt: got %0d want 5", bus.stall_cnt);
        end
        $display("timeout: err=%b stall_cnt=%0d", bus.lsu_timeout_err, bus.stall_cnt);
        step();
        n_vec++;
        if (bus.lsu_timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL to_sticky: got %b want 1", bus.lsu_timeout_err);
        end
        // Re-enter LSU_WAIT, then reset in the middle of the wait
        bus.exe_ls = 1'b1;
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({ctl, bus.lsu_timeout_err, bus.stall_cnt, bus.flush_cnt} !== {C_NONE, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
            n_err++;
            $display("FAIL to_async_rst: ctl=%b err=%b stall=%0d flush=%0d want all 0",
                     ctl, bus.lsu_timeout_err, bus.stall_cnt, bus.flush_cnt);
        end
        bus.exe_ls = 1'b0;
        #1;
        rstn = 1'b1;
        #1;
        n_vec++;
        if ({ctl, bus.lsu_timeout_err} !== {C_NONE, 1'b0}) begin
            n_err++;
            $display("FAIL to_after_rst: ctl=%b err=%b want %b 0", ctl, bus.lsu_timeout_err, C_NONE);
        end
        $display("reset mid-wait: ctl=%b err=%b", ctl, bus.lsu_timeout_err);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tgt = 32'h0000_0010 * (c + 1);
            bus.exe_redirect = 1'b1;
            bus.exe_target   = tgt;
            #1;
            n_vec++;
            if ({ctl, bus.redirect_pc} !== {C_REDIR, tgt}) begin
                n_err++;
                $display("FAIL b2b_redir_c%0d: ctl=%b pc=%h want %b %h", c, ctl, bus.redirect_pc, C_REDIR, tgt);
            end
            step();
        end
        clear_inputs();
        // Two different load-use hazards in consecutive cycles
        set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        #1;
        n_vec++;
        if (ctl !== C_LU) begin
            n_err++;
            $display("FAIL b2b_lu0: got %b want %b", ctl, C_LU);
        end
        step();
        set_load(5'd12, 5'd1, 1'b1, 5'd12, 1'b1);
        #1;
        n_vec++;
        if (ctl !== C_LU) begin
            n_err++;
            $display("FAIL b2b_lu1: got %b want %b", ctl, C_LU);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({bus.flush_cnt, bus.stall_cnt} !== {CNT_W'(3), CNT_W'(2)}) begin
            n_err++;
            $display("FAIL b2b_cnts: flush=%0d stall=%0d want 3 2", bus.flush_cnt, bus.stall_cnt);
        end
        $display("back-to-back: flush_cnt=%0d stall_cnt=%0d", bus.flush_cnt, bus.stall_cnt);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_x0();
        test_redirect();
        test_lsu_wait();
        test_csr();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "simulation time limit");
    end
endmodule
